// File: rtl/uart_rx_buffer_if.sv
// Wishbone slave bus bundle for the UART receive buffer.
// The master modport drives requests; the slave modport returns ack and read data.
interface uart_rx_buffer_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/uart_rx_buffer.sv
// UART receive FIFO with DATA/STATUS/CTRL Wishbone registers and a level interrupt.
// Registered single-cycle ack; received bytes are dropped (overrun flagged) when full.
module uart_rx_buffer #(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_2000
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    uart_rx_buffer_if.slave    wbs,
    input  logic [7:0]         rx_data_i,
    input  logic               rx_valid_i,
    input  logic               rx_frame_err_i,
    output logic               irq_o,
    output logic               rx_active_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic          ovr, ferr, irq_en;
    logic [7:0]    thresh;

    logic          hit, accept, empty, full, pop, push_ok, ovr_set, ferr_set;
    logic          lane0_wr, stat_wr, ctrl_wr;
    logic [3:0]    off;
    logic [8:0]    cnt9, thr9;
    logic [7:0]    cnt8;
    logic [31:0]   rdata;

    assign hit    = (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign accept = wbs.wbs_stb_i & wbs.wbs_cyc_i & hit & ~wbs.wbs_ack_o;
    assign off    = wbs.wbs_adr_i[3:0];

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A pop in the same cycle frees the slot, so a push into a full FIFO is only lost without one.
    assign pop      = accept & ~wbs.wbs_we_i & (off == 4'h0) & ~empty;
    assign push_ok  = rx_valid_i & (~full | pop);
    assign ovr_set  = rx_valid_i & full & ~pop;
    assign ferr_set = rx_valid_i & rx_frame_err_i;

    assign lane0_wr = accept & wbs.wbs_we_i & wbs.wbs_sel_i[0];
    assign stat_wr  = lane0_wr & (off == 4'h4);
    assign ctrl_wr  = lane0_wr & (off == 4'h8);

    assign count_next = count + CW'(push_ok) - CW'(pop);

    assign cnt9 = 9'(count);
    assign cnt8 = cnt9[8] ? 8'hFF : cnt9[7:0];
    assign thr9 = (thresh == 8'd0) ? 9'd1 : {1'b0, thresh};

    always_comb begin
        rdata = '0;
        if (!wbs.wbs_we_i) begin
            case (off)
                4'h0:    rdata = empty ? 32'd0 : {23'd0, 1'b1, mem[rd_ptr]};
                4'h4:    rdata = {16'd0, cnt8, 4'd0, ovr, ferr, full, empty};
                4'h8:    rdata = {23'd0, irq_en, thresh};
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= rx_data_i;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            ovr           <= 1'b0;
            ferr          <= 1'b0;
            irq_en        <= 1'b0;
            thresh        <= '0;
            wbs.wbs_ack_o <= 1'b0;
            wbs.wbs_dat_o <= '0;
            irq_o         <= 1'b0;
            rx_active_o   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count       <= count_next;
            rx_active_o <= (count_next != '0);

            // Clear first, then set, so a new error in the clearing cycle is kept.
            ovr  <= (ovr  & ~(stat_wr & wbs.wbs_dat_i[3])) | ovr_set;
            ferr <= (ferr & ~(stat_wr & wbs.wbs_dat_i[2])) | ferr_set;

            if (ctrl_wr) begin
                irq_en <= wbs.wbs_dat_i[8];
                thresh <= wbs.wbs_dat_i[7:0];
            end

            wbs.wbs_ack_o <= accept;
            wbs.wbs_dat_o <= accept ? rdata : 32'd0;
            irq_o         <= irq_en & ((cnt9 >= thr9) | ovr | ferr);
        end
    end
endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed and randomized checks of uart_rx_buffer against a queue-based register model.
module tb_uart_rx_buffer;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h3000_2000;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic [7:0] rx_data_i = '0;
    logic       rx_valid_i = 1'b0;
    logic       rx_frame_err_i = 1'b0;
    logic       irq_o, rx_active_o;

    uart_rx_buffer_if bus();

    uart_rx_buffer #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .wb_clk_i       (wb_clk_i),
        .wb_rst_i       (wb_rst_i),
        .wbs            (bus.slave),
        .rx_data_i      (rx_data_i),
        .rx_valid_i     (rx_valid_i),
        .rx_frame_err_i (rx_frame_err_i),
        .irq_o          (irq_o),
        .rx_active_o    (rx_active_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: byte queue plus sticky flags and control fields.
    logic [7:0] mq[$];
    bit         m_ovr, m_ferr, m_irq_en;
    logic [7:0] m_thr;

    function automatic logic [31:0] m_status();
        int c = mq.size();
        logic [7:0] c8 = (c > 255) ? 8'hFF : 8'(c);
        return {16'd0, c8, 4'd0, m_ovr, m_ferr, c == DEPTH, c == 0};
    endfunction

    function automatic bit m_irq();
        int t = (m_thr == 0) ? 1 : int'(m_thr);
        return m_irq_en && ((mq.size() >= t) || m_ovr || m_ferr);
    endfunction

    function automatic void m_push(input logic [7:0] d, input bit fe);
        if (fe) m_ferr = 1;
        if (mq.size() == DEPTH) m_ovr = 1;
        else mq.push_back(d);
    endfunction

    function automatic logic [31:0] m_pop();
        if (mq.size() == 0) return 32'd0;
        return {23'd0, 1'b1, mq.pop_front()};
    endfunction

    task automatic bus_idle();
        bus.wbs_stb_i = 0; bus.wbs_cyc_i = 0; bus.wbs_we_i = 0;
        bus.wbs_sel_i = 0; bus.wbs_dat_i = 0; bus.wbs_adr_i = 0;
        rx_valid_i = 0; rx_data_i = 0; rx_frame_err_i = 0;
    endtask

    // One bus request held for a single cycle, optionally with a byte arriving in the same cycle.
    task automatic wb_cycle(input logic [31:0] adr, input logic we, input logic [31:0] wd,
                            input logic [3:0] sel, input bit psh, input logic [7:0] pd,
                            input bit pfe, output logic [31:0] rd, output logic acked);
        @(negedge wb_clk_i);
        bus.wbs_stb_i = 1; bus.wbs_cyc_i = 1; bus.wbs_we_i = we;
        bus.wbs_sel_i = sel; bus.wbs_dat_i = wd; bus.wbs_adr_i = adr;
        rx_valid_i = psh; rx_data_i = pd; rx_frame_err_i = pfe;
        @(posedge wb_clk_i); #1;
        acked = bus.wbs_ack_o;
        rd    = bus.wbs_dat_o;
        @(negedge wb_clk_i);
        bus_idle();
    endtask

    task automatic push_byte(input logic [7:0] d, input bit fe);
        @(negedge wb_clk_i);
        rx_valid_i = 1; rx_data_i = d; rx_frame_err_i = fe;
        m_push(d, fe);
        @(negedge wb_clk_i);
        rx_valid_i = 0; rx_frame_err_i = 0;
    endtask

    task automatic do_reset();
        @(negedge wb_clk_i);
        bus_idle();
        wb_rst_i = 1;
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 0;
        mq.delete(); m_ovr = 0; m_ferr = 0; m_irq_en = 0; m_thr = 0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic ak;
        bus_idle();
        wb_rst_i = 1;
        @(posedge wb_clk_i); #1;
        if (bus.wbs_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", bus.wbs_ack_o); end
        n_checks++;
        if (bus.wbs_dat_o !== 32'd0) begin n_fail++; $display("FAIL reset_dat got %h want 0", bus.wbs_dat_o); end
        n_checks++;
        if (irq_o !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq_o); end
        n_checks++;
        if (rx_active_o !== 1'b0) begin n_fail++; $display("FAIL reset_active got %b want 0", rx_active_o); end
        n_checks++;
        do_reset();
        wb_cycle(BASE + 4, 0, 0, 4'hF, 0, 0, 0, rd, ak);
        if (ak !== 1'b1 || rd !== 32'h0000_0001) begin
            n_fail++; $display("FAIL reset_status got ack=%b %h want ack=1 00000001", ak, rd);
        end
        n_checks++;
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic ak;
        do_reset();
        push_byte(8'h41, 0);
        push_byte(8'h42, 0);
        wb_cycle(BASE, 0, 0, 4'hF, 0, 0, 0, rd, ak);
        if (rd !== 32'h141) begin n_fail++; $display("FAIL basic_rd1 got %h want 00000141", rd); end
        n_checks++;
        if (rx_active_o !== 1'b1) begin n_fail++; $display("FAIL basic_active1 got %b want 1", rx_active_o); end
        n_checks++;
        wb_cycle(BASE, 0, 0, 4'hF, 0, 0, 0, rd, ak);
        if (rd !== 32'h142) begin n_fail++; $display("FAIL basic_rd2 got %h want 00000142", rd); end
        n_checks++;
        if (rx_active_o !== 1'b0) begin n_fail++; $display("FAIL basic_active2 got %b want 0", rx_active_o); end
        n_checks++;
        wb_cycle(BASE, 0, 0, 4'hF, 0, 0, 0, rd, ak);
        if (ak !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL basic_rd_empty got ack=%b %h want ack=1 0", ak, rd); end
        n_checks++;
        wb_cycle(BASE + 4, 0, 0, 4'hF, 0, 0, 0, rd, ak);
        if (rd !== 32'h1) begin n_fail++; $display("FAIL basic_status got %h want 00000001", rd); end
        n_checks++;
    endtask

    task automatic test_overrun();
        logic [31:0] rd; logic ak;
        logic [7:0] first;
        do_reset();
        first = 8'($urandom);
        push_byte(first, 0);
        for (int i = 1; i < 17; i++) push_byte(8'($urandom), 0);
        wb_cycle(BASE + 4, 0, 0, 4'hF, 0, 0, 0, rd, ak);
        if (rd !== 32'h0000_100A) begin n_fail++; $display("FAIL ovr_status got %h want 0000100a", rd); end
        n_checks++;
        wb_cycle(BASE, 0, 0, 4'hF, 0, 0, 0, rd, ak);
        if (rd !== {23'd0, 1'b1, first}) begin n_fail++; $display("FAIL ovr_first got %h want %h", rd, {23'd0, 1'b1, first}); end
        n_checks++;
    endtask

    task automatic test_full_push_pop();
        logic [31:0] rd, exp; logic ak;
        logic [7:0] nb;
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom), 0);
        nb  = 8'($urandom);
        exp = m_pop();
        m_push(nb, 0);
        wb_cycle(BASE, 0, 0, 4'hF, 1, nb, 0, rd, ak);
        if (rd !== exp) begin n_fail++; $display("FAIL full_pp_data got %h want %h", rd, exp); end
        n_checks++;
        wb_cycle(BASE + 4, 0, 0, 4'hF, 0, 0, 0, rd, ak);
        if (rd !== 32'h0000_1002) begin n_fail++; $display("FAIL full_pp_status got %h want 00001002", rd); end
        n_checks++;
        for (int i = 0; i < DEPTH; i++) begin
            exp = m_pop();
            wb_cycle(BASE, 0, 0, 4'hF, 0, 0, 0, rd, ak);
            if (rd !== exp) begin n_fail++; $display("FAIL full_pp_drain%0d got %h want %h", i, rd, exp); end
            n_checks++;
        end
        // Empty pop with a simultaneous push: no bypass, byte remains.
        wb_cycle(BASE, 0, 0, 4'hF, 1, 8'h5A, 0, rd, ak);
        if (rd !== 32'h0) begin n_fail++; $display("FAIL empty_pp_data got %h want 0", rd); end
        n_checks++;
        wb_cycle(BASE, 0, 0, 4'hF, 0, 0, 0, rd, ak);
        if (rd !== 32'h15A) begin n_fail++; $display("FAIL empty_pp_kept got %h want 0000015a", rd); end
        n_checks++;
    endtask

    task automatic test_irq();
        logic [31:0] rd; logic ak;
        do_reset();
        wb_cycle(BASE + 8, 1, 32'h104, 4'h1, 0, 0, 0, rd, ak);
        wb_cycle(BASE + 8, 0, 0, 4'hF, 0, 0, 0, rd, ak);
        if (rd !== 32'h104) begin n_fail++; $display("FAIL irq_ctrl got %h want 00000104", rd); end
        n_checks++;
        for (int i = 0; i < 3; i++) push_byte(8'(i), 0);
        @(posedge wb_clk_i); #1;
        if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_below got %b want 0", irq_o); end
        n_checks++;
        push_byte(8'h33, 0);
        @(posedge wb_clk_i); #1;
        if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_at_thresh got %b want 1", irq_o); end
        n_checks++;
        wb_cycle(BASE, 0, 0, 4'hF, 0, 0, 0, rd, ak);
        @(posedge wb_clk_i); #1;
        if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_after_pop got %b want 0", irq_o); end
        n_checks++;
    endtask

    task automatic test_ferr_window();
        logic [31:0] rd; logic ak;
        do_reset();
        push_byte(8'h77, 1);
        wb_cycle(BASE + 4, 0, 0, 4'hF, 0, 0, 0, rd, ak);
        if (rd !== 32'h0000_0104) begin n_fail++; $display("FAIL ferr_set got %h want 00000104", rd); end
        n_checks++;
        wb_cycle(BASE + 4, 1, 32'h4, 4'h1, 0, 0, 0, rd, ak);
        wb_cycle(BASE + 4, 0, 0, 4'hF, 0, 0, 0, rd, ak);
        if (rd !== 32'h0000_0100) begin n_fail++; $display("FAIL ferr_clear got %h want 00000100", rd); end
        n_checks++;
        // Clear and new error together: the new error survives.
        wb_cycle(BASE + 4, 1, 32'h4, 4'h1, 1, 8'h78, 1, rd, ak);
        wb_cycle(BASE + 4, 0, 0, 4'hF, 0, 0, 0, rd, ak);
        if (rd !== 32'h0000_0204) begin n_fail++; $display("FAIL ferr_set_wins got %h want 00000204", rd); end
        n_checks++;
        wb_cycle(BASE + 32'h10, 0, 0, 4'hF, 0, 0, 0, rd, ak);
        if (ak !== 1'b0) begin n_fail++; $display("FAIL outside_noack got %b want 0", ak); end
        n_checks++;
        wb_cycle(BASE + 32'hC, 0, 0, 4'hF, 0, 0, 0, rd, ak);
        if (ak !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL reg_c got ack=%b %h want ack=1 0", ak, rd); end
        n_checks++;
        wb_cycle(BASE + 4, 0, 0, 4'hF, 0, 0, 0, rd, ak);
        if (rd !== 32'h0000_0204) begin n_fail++; $display("FAIL no_side_effect got %h want 00000204", rd); end
        n_checks++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic ak;
        int acks = 0;
        do_reset();
        for (int i = 0; i < 5; i++) push_byte(8'(8'hA0 + i), 0);
        @(negedge wb_clk_i);
        bus.wbs_stb_i = 1; bus.wbs_cyc_i = 1; bus.wbs_we_i = 0;
        bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = BASE;
        for (int i = 0; i < 6; i++) begin
            @(posedge wb_clk_i); #1;
            if (bus.wbs_ack_o !== ((i % 2) == 0)) begin
                n_fail++; $display("FAIL b2b_ack%0d got %b want %b", i, bus.wbs_ack_o, (i % 2) == 0);
            end
            n_checks++;
            if (bus.wbs_ack_o === 1'b1) begin
                if (bus.wbs_dat_o !== {23'd0, 1'b1, 8'(8'hA0 + acks)}) begin
                    n_fail++; $display("FAIL b2b_dat%0d got %h want %h", acks, bus.wbs_dat_o, {23'd0, 1'b1, 8'(8'hA0 + acks)});
                end
                n_checks++;
                acks++;
            end
        end
        @(negedge wb_clk_i);
        bus_idle();
        wb_cycle(BASE + 4, 0, 0, 4'hF, 0, 0, 0, rd, ak);
        if (rd !== 32'h0000_0200) begin n_fail++; $display("FAIL b2b_status got %h want 00000200", rd); end
        n_checks++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic ak;
        do_reset();
        for (int i = 0; i < 3; i++) push_byte(8'(i + 1), 0);
        @(negedge wb_clk_i);
        bus.wbs_stb_i = 1; bus.wbs_cyc_i = 1; bus.wbs_we_i = 0;
        bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = BASE;
        wb_rst_i = 1;
        @(posedge wb_clk_i); #1;
        if (bus.wbs_ack_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ack got %b want 0", bus.wbs_ack_o); end
        n_checks++;
        @(negedge wb_clk_i);
        bus_idle();
        wb_rst_i = 0;
        mq.delete(); m_ovr = 0; m_ferr = 0; m_irq_en = 0; m_thr = 0;
        wb_cycle(BASE + 4, 0, 0, 4'hF, 0, 0, 0, rd, ak);
        if (rd !== 32'h1) begin n_fail++; $display("FAIL rst_mid_status got %h want 00000001", rd); end
        n_checks++;
    endtask

    task automatic test_random();
        logic [31:0] rd, exp, adr, wd; logic ak, exp_ak, we;
        logic [3:0] sel, off;
        logic [7:0] pd;
        bit psh, pfe, inwin;
        do_reset();
        for (int it = 0; it < 400; it++) begin
            psh = ($urandom_range(0, 99) < 45);
            pd  = 8'($urandom);
            pfe = ($urandom_range(0, 99) < 8);
            we  = ($urandom_range(0, 99) < 30);
            sel = 4'($urandom);
            wd  = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: off = 4'h0;
                4, 5:       off = 4'h4;
                6, 7:       off = 4'h8;
                default:    off = 4'($urandom);
            endcase
            inwin = ($urandom_range(0, 99) >= 5);
            adr = inwin ? (BASE | 32'(off)) : (BASE + 32'h10 + 32'($urandom_range(0, 255) << 4) + 32'(off));
            if (we && off == 4'h8 && sel[0]) wd = {23'd0, 1'($urandom), 8'($urandom_range(0, 20))};
            exp = 32'd0;
            exp_ak = inwin;
            if (inwin) begin
                if (!we) begin
                    case (off)
                        4'h0:    exp = m_pop();
                        4'h4:    exp = m_status();
                        4'h8:    exp = {23'd0, m_irq_en, m_thr};
                        default: exp = 32'd0;
                    endcase
                end else if (sel[0]) begin
                    if (off == 4'h4) begin
                        if (wd[3]) m_ovr = 0;
                        if (wd[2]) m_ferr = 0;
                    end else if (off == 4'h8) begin
                        m_irq_en = wd[8]; m_thr = wd[7:0];
                    end
                end
            end
            if (psh) m_push(pd, pfe);
            wb_cycle(adr, we, wd, sel, psh, pd, pfe, rd, ak);
            if (ak !== exp_ak || rd !== exp) begin
                n_fail++;
                $display("FAIL rand%0d adr=%h we=%b got ack=%b %h want ack=%b %h", it, adr, we, ak, rd, exp_ak, exp);
            end
            n_checks++;
            @(posedge wb_clk_i); #1;
            if (irq_o !== m_irq() || rx_active_o !== (mq.size() != 0)) begin
                n_fail++;
                $display("FAIL rand_out%0d got irq=%b active=%b want irq=%b active=%b", it, irq_o, rx_active_o, m_irq(), mq.size() != 0);
            end
            n_checks++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_full_push_pop();
        test_irq();
        test_ferr_window();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
